// File: rtl/branch_rs.sv
// Branch reservation station: compacting in-order queue with CDB wake-up and oldest-ready issue.
// Optional `BRS_CDB_FWD_ISSUE_EN lets an entry woken by the CDB issue in the same cycle.
module branch_rs_wake #(
    parameter int TAG_W = 5
) (
    input  logic             rdy,
    input  logic [TAG_W-1:0] tag,
    input  logic [31:0]      src,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_data,
    output logic             rdy_w,
    output logic [31:0]      src_w
);
    logic hit;
    assign hit   = ~rdy & cdb_valid & (tag == cdb_tag);
    assign rdy_w = rdy | hit;
    assign src_w = hit ? cdb_data : src;
endmodule

module branch_rs #(
    parameter int ENTRY_NUM = 4,
    parameter int TAG_W     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Flush,
    input  logic             Dispatch_valid,
    input  logic [5:0]       Dispatch_Op,
    input  logic [31:0]      Dispatch_Src1,
    input  logic [31:0]      Dispatch_Src2,
    input  logic             Dispatch_Rdy1,
    input  logic             Dispatch_Rdy2,
    input  logic [TAG_W-1:0] Dispatch_Tag1,
    input  logic [TAG_W-1:0] Dispatch_Tag2,
    input  logic [31:0]      Dispatch_ime,
    input  logic [31:0]      Dispatch_PC,
    input  logic [TAG_W-1:0] Dispatch_ROB,
    output logic             Full,
    input  logic             CDB_valid,
    input  logic [TAG_W-1:0] CDB_tag,
    input  logic [31:0]      CDB_data,
    output logic             Issue_valid,
    output logic [5:0]       Issue_Op,
    output logic [31:0]      Issue_Src1,
    output logic [31:0]      Issue_Src2,
    output logic [31:0]      Issue_ime,
    output logic [31:0]      Issue_PC,
    output logic [31:0]      Issue_PC_plus_4,
    output logic [31:0]      Issue_PC_plus_8,
    output logic [TAG_W-1:0] Issue_ROB
);
    localparam int CW = $clog2(ENTRY_NUM + 1);

    typedef struct packed {
        logic [5:0]       op;
        logic [31:0]      src1;
        logic [31:0]      src2;
        logic             rdy1;
        logic             rdy2;
        logic [TAG_W-1:0] tag1;
        logic [TAG_W-1:0] tag2;
        logic [31:0]      ime;
        logic [31:0]      pc;
        logic [TAG_W-1:0] rob;
    } entry_t;

    entry_t [ENTRY_NUM-1:0]        ent_q, ent_w, ent_n;
    logic   [ENTRY_NUM-1:0]        w_rdy1, w_rdy2, vld, rdy_sel;
    logic   [ENTRY_NUM-1:0][31:0]  w_src1, w_src2;
    entry_t                        disp_e, disp_w, sel_e;
    logic                          d_rdy1, d_rdy2;
    logic   [31:0]                 d_src1, d_src2;
    logic   [CW-1:0]               count, count_n, sel_idx, wr_idx;
    logic                          sel_found, accept;

    assign Full   = (count == CW'(ENTRY_NUM));
    assign accept = Dispatch_valid & ~Full & ~Flush;

    // Per-entry operand snooping, one instance per source.
    for (genvar g = 0; g < ENTRY_NUM; g++) begin : g_ent
        branch_rs_wake #(.TAG_W(TAG_W)) u_w1 (
            .rdy(ent_q[g].rdy1), .tag(ent_q[g].tag1), .src(ent_q[g].src1),
            .cdb_valid(CDB_valid), .cdb_tag(CDB_tag), .cdb_data(CDB_data),
            .rdy_w(w_rdy1[g]), .src_w(w_src1[g]));
        branch_rs_wake #(.TAG_W(TAG_W)) u_w2 (
            .rdy(ent_q[g].rdy2), .tag(ent_q[g].tag2), .src(ent_q[g].src2),
            .cdb_valid(CDB_valid), .cdb_tag(CDB_tag), .cdb_data(CDB_data),
            .rdy_w(w_rdy2[g]), .src_w(w_src2[g]));
        assign vld[g] = (CW'(g) < count);
`ifdef BRS_CDB_FWD_ISSUE_EN
        assign rdy_sel[g] = vld[g] & w_rdy1[g] & w_rdy2[g];
`else
        assign rdy_sel[g] = vld[g] & ent_q[g].rdy1 & ent_q[g].rdy2;
`endif
    end

    branch_rs_wake #(.TAG_W(TAG_W)) u_dw1 (
        .rdy(Dispatch_Rdy1), .tag(Dispatch_Tag1), .src(Dispatch_Src1),
        .cdb_valid(CDB_valid), .cdb_tag(CDB_tag), .cdb_data(CDB_data),
        .rdy_w(d_rdy1), .src_w(d_src1));
    branch_rs_wake #(.TAG_W(TAG_W)) u_dw2 (
        .rdy(Dispatch_Rdy2), .tag(Dispatch_Tag2), .src(Dispatch_Src2),
        .cdb_valid(CDB_valid), .cdb_tag(CDB_tag), .cdb_data(CDB_data),
        .rdy_w(d_rdy2), .src_w(d_src2));

    always_comb begin
        disp_e = '{op: Dispatch_Op, src1: Dispatch_Src1, src2: Dispatch_Src2,
                   rdy1: Dispatch_Rdy1, rdy2: Dispatch_Rdy2,
                   tag1: Dispatch_Tag1, tag2: Dispatch_Tag2,
                   ime: Dispatch_ime, pc: Dispatch_PC, rob: Dispatch_ROB};
        disp_w      = disp_e;
        disp_w.rdy1 = d_rdy1;
        disp_w.src1 = d_src1;
        disp_w.rdy2 = d_rdy2;
        disp_w.src2 = d_src2;
    end

    always_comb begin
        ent_w = ent_q;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            ent_w[i].rdy1 = w_rdy1[i];
            ent_w[i].src1 = w_src1[i];
            ent_w[i].rdy2 = w_rdy2[i];
            ent_w[i].src2 = w_src2[i];
        end
    end

    // Oldest ready entry wins: scan from the top so index 0 ends up last.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_e     = '0;
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            if (rdy_sel[i]) begin
                sel_found = 1'b1;
                sel_idx   = CW'(i);
                sel_e     = ent_w[i];
            end
        end
    end

    always_comb begin
        ent_n = ent_w;
        for (int i = 0; i < ENTRY_NUM - 1; i++) begin
            if (sel_found && (CW'(i) >= sel_idx)) ent_n[i] = ent_w[i+1];
        end
        wr_idx = sel_found ? count - CW'(1) : count;
        if (accept) begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                if (CW'(i) == wr_idx) ent_n[i] = disp_w;
            end
        end
        count_n = count + CW'(accept) - CW'(sel_found);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count           <= '0;
            ent_q           <= '0;
            Issue_valid     <= 1'b0;
            Issue_Op        <= '0;
            Issue_Src1      <= '0;
            Issue_Src2      <= '0;
            Issue_ime       <= '0;
            Issue_PC        <= '0;
            Issue_PC_plus_4 <= '0;
            Issue_PC_plus_8 <= '0;
            Issue_ROB       <= '0;
        end else if (Flush) begin
            count       <= '0;
            Issue_valid <= 1'b0;
        end else begin
            count       <= count_n;
            ent_q       <= ent_n;
            Issue_valid <= sel_found;
            if (sel_found) begin
                Issue_Op        <= sel_e.op;
                Issue_Src1      <= sel_e.src1;
                Issue_Src2      <= sel_e.src2;
                Issue_ime       <= sel_e.ime;
                Issue_PC        <= sel_e.pc;
                Issue_PC_plus_4 <= sel_e.pc + 32'd4;
                Issue_PC_plus_8 <= sel_e.pc + 32'd8;
                Issue_ROB       <= sel_e.rob;
            end
        end
    end
endmodule

// File: tb/tb_branch_rs.sv
// Randomized + directed bench for branch_rs against a queue-based reference model.
module tb_branch_rs;
    localparam int N = 4;
    localparam int TW = 5;
`ifdef BRS_CDB_FWD_ISSUE_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam logic [5:0] BEQ = 6'd4;

    logic clk = 1'b0, rst = 1'b1, flush = 1'b0, dv = 1'b0;
    logic [5:0] d_op = '0;
    logic [31:0] d_s1 = '0, d_s2 = '0, d_ime = '0, d_pc = '0, cdb_d = '0;
    logic d_r1 = 1'b0, d_r2 = 1'b0, cdb_v = 1'b0;
    logic [TW-1:0] d_t1 = '0, d_t2 = '0, d_rob = '0, cdb_t = '0;
    logic full, iv;
    logic [5:0] i_op;
    logic [31:0] i_s1, i_s2, i_ime, i_pc, i_pc4, i_pc8;
    logic [TW-1:0] i_rob;

    branch_rs #(.ENTRY_NUM(N), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst), .Flush(flush), .Dispatch_valid(dv), .Dispatch_Op(d_op),
        .Dispatch_Src1(d_s1), .Dispatch_Src2(d_s2), .Dispatch_Rdy1(d_r1), .Dispatch_Rdy2(d_r2),
        .Dispatch_Tag1(d_t1), .Dispatch_Tag2(d_t2), .Dispatch_ime(d_ime), .Dispatch_PC(d_pc),
        .Dispatch_ROB(d_rob), .Full(full), .CDB_valid(cdb_v), .CDB_tag(cdb_t), .CDB_data(cdb_d),
        .Issue_valid(iv), .Issue_Op(i_op), .Issue_Src1(i_s1), .Issue_Src2(i_s2),
        .Issue_ime(i_ime), .Issue_PC(i_pc), .Issue_PC_plus_4(i_pc4), .Issue_PC_plus_8(i_pc8),
        .Issue_ROB(i_rob));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] op; logic [31:0] s1, s2; logic r1, r2;
        logic [TW-1:0] t1, t2; logic [31:0] ime, pc; logic [TW-1:0] rob;
    } ment_t;

    ment_t mq[$];
    ment_t e_is;
    bit e_iv;
    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic ment_t wake(input ment_t e);
        ment_t r = e;
        if (cdb_v && !r.r1 && r.t1 == cdb_t) begin r.s1 = cdb_d; r.r1 = 1'b1; end
        if (cdb_v && !r.r2 && r.t2 == cdb_t) begin r.s2 = cdb_d; r.r2 = 1'b1; end
        return r;
    endfunction

    task automatic model_reset();
        mq.delete();
        e_iv = 1'b0;
        e_is = '0;
    endtask

    // One clock of the reference: oldest ready issues, the rest keep order, new one joins the tail.
    task automatic model_step();
        ment_t w[$];
        ment_t e;
        int pick;
        bit was_full;
        pick = -1;
        was_full = (mq.size() == N);
        if (rst) begin model_reset(); return; end
        if (flush) begin mq.delete(); e_iv = 1'b0; return; end
        foreach (mq[i]) begin
            e = mq[i];
            if (!FWD && pick < 0 && e.r1 && e.r2) pick = i;
            e = wake(e);
            if (FWD && pick < 0 && e.r1 && e.r2) pick = i;
            w.push_back(e);
        end
        e_iv = (pick >= 0);
        if (e_iv) begin e_is = w[pick]; w.delete(pick); end
        if (dv && !was_full) begin
            e = '{op: d_op, s1: d_s1, s2: d_s2, r1: d_r1, r2: d_r2, t1: d_t1, t2: d_t2,
                  ime: d_ime, pc: d_pc, rob: d_rob};
            w.push_back(wake(e));
        end
        mq = w;
    endtask

    task automatic compare();
        chk("full", full, 32'(mq.size() == N));
        chk("issue_valid", iv, 32'(e_iv));
        if (e_iv) begin
            chk("issue_op", 32'(i_op), 32'(e_is.op));
            chk("issue_src1", i_s1, e_is.s1);
            chk("issue_src2", i_s2, e_is.s2);
            chk("issue_ime", i_ime, e_is.ime);
            chk("issue_pc", i_pc, e_is.pc);
            chk("issue_pc4", i_pc4, e_is.pc + 32'd4);
            chk("issue_pc8", i_pc8, e_is.pc + 32'd8);
            chk("issue_rob", 32'(i_rob), 32'(e_is.rob));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic idle();
        dv = 1'b0; flush = 1'b0; cdb_v = 1'b0;
    endtask

    task automatic disp(input logic [5:0] op, input logic [31:0] s1, input logic r1,
                        input logic [TW-1:0] t1, input logic [31:0] s2, input logic r2,
                        input logic [TW-1:0] t2, input logic [31:0] pc, input logic [TW-1:0] rob);
        dv = 1'b1; d_op = op; d_s1 = s1; d_r1 = r1; d_t1 = t1; d_s2 = s2; d_r2 = r2; d_t2 = t2;
        d_pc = pc; d_rob = rob; d_ime = $urandom;
    endtask

    task automatic cdb(input logic [TW-1:0] t, input logic [31:0] d);
        cdb_v = 1'b1; cdb_t = t; cdb_d = d;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        #1;
        chk("rst_full", full, 0);
        chk("rst_iv", iv, 0);
        chk("rst_src1", i_s1, 0);
        chk("rst_pc8", i_pc8, 0);
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_issue(input string tag, input int budget);
        int k;
        k = 0;
        while (!iv && k < budget) begin tick(); k++; end
        chk(tag, iv, 1);
    endtask

    initial begin
        #1;
        do_reset();

        // Ready-at-dispatch latency: issue two edges later.
        disp(BEQ, 32'd5, 1, 0, 32'd5, 1, 0, 32'h100, 5'd1);
        tick(); idle();
        chk("lat_n1_iv", iv, 0);
        tick();
        chk("lat_n2_iv", iv, 1);
        chk("lat_op", 32'(i_op), 32'(BEQ));
        chk("lat_src1", i_s1, 5);
        chk("lat_src2", i_s2, 5);
        tick();

        // Fill, overflow attempt, wake the middle entry.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            disp(BEQ, 0, 0, TW'(10 + i), 0, 1, 0, 32'h200 + 32'(4 * i), TW'(i));
            tick();
        end
        chk("full_set", full, 1);
        disp(BEQ, 0, 1, 0, 0, 1, 0, 32'h300, 5'd9);
        tick(); idle();
        cdb(5'd12, 32'h55);
        tick(); idle();
        wait_issue("full_wake_wait", 4);
        chk("full_wake_rob", 32'(i_rob), 2);
        chk("full_wake_src1", i_s1, 32'h55);
        tick();
        chk("full_clear", full, 0);

        // Two entries on the same tag: oldest first.
        do_reset();
        disp(BEQ, 0, 0, 5'd3, 1, 1, 0, 32'h400, 5'd20); tick();
        disp(BEQ, 0, 0, 5'd3, 2, 1, 0, 32'h404, 5'd21); tick(); idle();
        cdb(5'd3, 32'h10); tick(); idle();
        wait_issue("same_tag_wait", 4);
        chk("same_tag_rob0", 32'(i_rob), 20);
        chk("same_tag_src0", i_s1, 32'h10);
        tick();
        chk("same_tag_iv1", iv, 1);
        chk("same_tag_rob1", 32'(i_rob), 21);
        chk("same_tag_src1", i_s1, 32'h10);

        // Dispatch-time capture, both sources on one tag.
        do_reset();
        disp(BEQ, 0, 0, 5'd7, 0, 0, 5'd7, 32'h500, 5'd4);
        cdb(5'd7, 32'hAB);
        tick(); idle();
        wait_issue("disp_wake_wait", 3);
        chk("disp_wake_src1", i_s1, 32'hAB);
        chk("disp_wake_src2", i_s2, 32'hAB);

        // PC wrap.
        do_reset();
        disp(BEQ, 1, 1, 0, 2, 1, 0, 32'hFFFF_FFFC, 5'd6);
        tick(); idle();
        wait_issue("wrap_wait", 3);
        chk("wrap_pc4", i_pc4, 32'h0);
        chk("wrap_pc8", i_pc8, 32'h4);

        // Flush beats dispatch and wake-up.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            disp(BEQ, 0, 0, TW'(20 + i), 0, 1, 0, 32'h600, TW'(i)); tick();
        end
        flush = 1'b1;
        disp(BEQ, 0, 1, 0, 0, 1, 0, 32'h700, 5'd9);
        cdb(5'd20, 32'h1);
        tick(); idle();
        chk("flush_full", full, 0);
        chk("flush_iv", iv, 0);
        for (int i = 0; i < 5; i++) begin
            cdb(TW'(20 + (i % 3)), 32'h2); tick();
            chk("flush_no_issue", iv, 0);
        end
        idle();

        // Wake-to-issue timing with and without CDB forwarding.
        disp(BEQ, 0, 0, 5'd9, 0, 1, 0, 32'h800, 5'd12); tick(); idle();
        tick();
        cdb(5'd9, 32'h99); tick(); idle();
        chk("fwd_t1_iv", iv, 32'(FWD));
        tick();
        chk("fwd_t2_iv", iv, 32'(!FWD));

        // Asynchronous reset mid-operation.
        disp(BEQ, 3, 1, 0, 3, 1, 0, 32'h900, 5'd1); tick();
        disp(BEQ, 3, 1, 0, 3, 1, 0, 32'h904, 5'd2); tick(); idle();
        #3 rst = 1'b1;
        #1;
        chk("async_full", full, 0);
        chk("async_iv", iv, 0);
        chk("async_src1", i_s1, 0);
        model_reset();
        tick();
        rst = 1'b0;

        // Random traffic.
        for (int c = 0; c < 2000; c++) begin
            dv = ($urandom % 3) != 0;
            d_op = 6'($urandom); d_s1 = $urandom; d_s2 = $urandom;
            d_r1 = 1'($urandom); d_r2 = 1'($urandom);
            d_t1 = TW'($urandom % 8); d_t2 = TW'($urandom % 8);
            d_ime = $urandom; d_pc = $urandom & 32'hFFFF_FFFC; d_rob = TW'($urandom);
            cdb_v = 1'($urandom); cdb_t = TW'($urandom % 8); cdb_d = $urandom;
            flush = ($urandom % 40) == 0;
            tick();
        end
        idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_rs.md
BRANCH_RS -- requirements
Module: branch_rs

Interface
REQ-001 Parameter ENTRY_NUM, default 4, SHALL set the number of reservation entries (2..8).
REQ-002 Parameter TAG_W, default 5, SHALL set the width of the ROB/rename tag.
REQ-003 clk  in  1  SHALL be the single clock; every register samples on its rising edge.
REQ-004 rst  in  1  SHALL be the reset; it is asynchronous and active-high.
REQ-005 Flush  in  1  SHALL be the misprediction/exception squash request.
REQ-006 Dispatch_valid  in  1  SHALL be the dispatch request.
REQ-007 Dispatch_Op  in  6  SHALL carry the BUOp code.
REQ-008 Dispatch_Src1/Dispatch_Src2  in  32 each  SHALL carry the operand values.
REQ-009 Dispatch_Rdy1/Dispatch_Rdy2  in  1 each  SHALL mark each operand as valid.
REQ-010 Dispatch_Tag1/Dispatch_Tag2  in  TAG_W each  SHALL carry the producer tag of each operand that is not ready.
REQ-011 Dispatch_ime, Dispatch_PC  in  32 each  SHALL carry the immediate/target field and the instruction PC.
REQ-012 Dispatch_ROB  in  TAG_W  SHALL carry the destination ROB tag.
REQ-013 Full  out  1  SHALL signal that no entry is free.
REQ-014 CDB_valid, CDB_tag, CDB_data  in  1/TAG_W/32  SHALL carry the result broadcast.
REQ-015 Issue_valid  out  1  SHALL be the issue strobe to BU.
REQ-016 Issue_Op  out  6  SHALL carry the issued operation.
REQ-017 Issue_Src1, Issue_Src2, Issue_ime, Issue_PC, Issue_PC_plus_4, Issue_PC_plus_8  out  32 each  SHALL carry the BU operands and PCs.
REQ-018 Issue_ROB  out  TAG_W  SHALL carry the ROB tag of the issued branch.

Function
REQ-019 Entries SHALL form a compacting queue: index 0 is the oldest, valid entries are contiguous from 0, and a new entry is written at index = current count.
REQ-020 Dispatch SHALL be accepted when Dispatch_valid=1, Full=0 and Flush=0; an accepted dispatch becomes selectable in the cycle after the write edge.
REQ-021 Full SHALL equal (count==ENTRY_NUM) from registered state; an issue in the same cycle SHALL NOT free a slot for a same-cycle dispatch.
REQ-022 Wake-up: when CDB_valid=1 and an entry's not-ready source has a tag equal to CDB_tag, the entry SHALL capture CDB_data and set that source ready at the edge.
REQ-023 Wake-up SHALL apply to both sources at once and to an entry being dispatched in the same cycle (dispatch-time tag match).
REQ-024 An entry is ready when both Rdy bits are set; the lowest-index ready entry SHALL be selected combinationally each cycle.
REQ-025 Issue registers SHALL load the selected entry at the edge, with Issue_valid=1 for exactly one cycle per issued entry and Issue_valid=0 when nothing is selected.
REQ-026 On issue, entries above the issued index SHALL shift down one position, and a same-cycle dispatch SHALL land at count-1.
REQ-027 Issue_PC_plus_4 SHALL be PC+4 and Issue_PC_plus_8 SHALL be PC+8, computed modulo 2^32 (wrap at 0xFFFFFFFC).
REQ-028 Latency: dispatch with both operands ready at cycle N SHALL produce Issue_valid in cycle N+2; at most one issue per cycle.
REQ-029 Flush SHALL invalidate all entries and clear Issue_valid at the next edge; Flush has priority over dispatch, wake-up and issue.
REQ-030 Dispatch with the same tag on both sources SHALL wake both sources from a single broadcast.

Reset
REQ-031 While rst=1, count SHALL be 0, all entries invalid, Full=0, Issue_valid=0, and all Issue_* data outputs 0.
REQ-032 Assertion of rst mid-operation SHALL discard all in-flight entries immediately, without waiting for a clock edge.

Configuration
REQ-033 Macro BRS_CDB_FWD_ISSUE_EN defined: an entry whose last missing operand matches the CDB in cycle t SHALL be selectable in cycle t, with CDB_data forwarded into the issue registers (Issue_valid in t+1).
REQ-034 Macro BRS_CDB_FWD_ISSUE_EN undefined: such an entry SHALL first become selectable in cycle t+1 (Issue_valid in t+2); all other behaviour is identical.

Verification
REQ-035 Reset then dispatch Beq with Src1=Src2=5, both ready, at cycle 1 -> Issue_valid=1 in cycle 3, Issue_Op=Beq, Issue_Src1=Issue_Src2=5.
REQ-036 Dispatch 4 entries, none ready -> Full=1; 5th dispatch ignored; CDB wakes entry 2 -> entry 2 issues, then Full=0 the following cycle.
REQ-037 Entries 0 and 1 both waiting on tag 3; CDB tag 3, data 0x10 -> entry 0 issues first, entry 1 next cycle, both with Src1=0x10.
REQ-038 Dispatch with Tag1=7 in the same cycle as CDB tag 7, data 0xAB -> entry stored ready with Src1=0xAB and issues without another broadcast.
REQ-039 Dispatch_PC=0xFFFFFFFC issued -> Issue_PC_plus_4=0x00000000, Issue_PC_plus_8=0x00000004.
REQ-040 3 valid entries plus Flush together with dispatch -> next cycle count=0, Full=0, Issue_valid=0, and no later issue; repeat with FWD macro on and off to check the 1-cycle difference of REQ-033/034.
